// File: rtl/ic_gate_tester.sv
// ic_gate_tester
//
// Self-checking tester for multi-gate 74xx logic ICs. One sweep applies every
// input combination (0 .. 2^N_IN-1) to all gate channels at once. After each
// vector has settled, every channel output is compared against the selected
// gate function. Per-channel mismatch flags, the first failing vector and an
// overall pass flag are reported through a start/done handshake.
//
// Ports
//   clk_in           single clock, all logic on the rising edge
//   rst_in           synchronous active-high reset
//   start_in         request a sweep (accepted only while idle)
//   mode_in          expected gate: 000 NAND, 001 NOR, 010 AND, 011 OR,
//                    100 XOR, 101 XNOR, 110 NOT (input bit 0), 111 reserved
//   dut_a_out        stimulus, channel c on bits [c*N_IN +: N_IN]
//   dut_y_in         gate outputs from the device under test, bit c = channel c
//   busy_out         sweep in progress (including the DONE cycle)
//   done_out         one-cycle pulse at the end of a run
//   pass_out         last run had no mismatch and a legal mode
//   fail_mask_out    sticky per-channel mismatch flags of the last run
//   fail_vector_out  first vector that produced any mismatch in the last run
//   err_mode_out     last run requested the reserved mode
module ic_gate_tester #(
    parameter int CHANNELS      = 4,
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic [2:0]               mode_in,
    output logic [CHANNELS*N_IN-1:0] dut_a_out,
    input  logic [CHANNELS-1:0]      dut_y_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     pass_out,
    output logic [CHANNELS-1:0]      fail_mask_out,
    output logic [N_IN-1:0]          fail_vector_out,
    output logic                     err_mode_out
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    // Counter is one bit wider than a vector so the last vector is detected
    // by value rather than by wrap-around.
    localparam logic [N_IN:0] V_LAST = (N_IN + 1)'((1 << N_IN) - 1);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          mode_q;
    logic [N_IN:0]       v_q;
    logic [SW-1:0]       settle_cnt;
    logic                expected;
    logic [CHANNELS-1:0] mismatch;
    logic                v_last;

    function automatic logic gate_eval(input logic [2:0] m, input logic [N_IN-1:0] vec);
        logic r;
        r = 1'b0;
        case (m)
            3'b000:  r = ~(&vec);
            3'b001:  r = ~(|vec);
            3'b010:  r = &vec;
            3'b011:  r = |vec;
            3'b100:  r = ^vec;
            3'b101:  r = ~(^vec);
            3'b110:  r = ~vec[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign expected = gate_eval(mode_q, v_q[N_IN-1:0]);
    assign mismatch = dut_y_in ^ {CHANNELS{expected}};
    assign v_last   = (v_q == V_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_nxt = (mode_in == 3'b111) ? DONE : APPLY;
                end
            end
            APPLY:  state_nxt = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CHECK;
                end
            end
            CHECK:  state_nxt = v_last ? DONE : APPLY;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mode_q          <= '0;
            v_q             <= '0;
            settle_cnt      <= '0;
            pass_out        <= 1'b0;
            fail_mask_out   <= '0;
            fail_vector_out <= '0;
            err_mode_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        mode_q          <= mode_in;
                        v_q             <= '0;
                        settle_cnt      <= '0;
                        pass_out        <= 1'b0;
                        fail_vector_out <= '0;
                        // Reserved mode ends the run at once with every channel flagged.
                        if (mode_in == 3'b111) begin
                            err_mode_out  <= 1'b1;
                            fail_mask_out <= '1;
                        end else begin
                            err_mode_out  <= 1'b0;
                            fail_mask_out <= '0;
                        end
                    end
                end
                APPLY:  settle_cnt <= '0;
                SETTLE: settle_cnt <= settle_cnt + SW'(1);
                CHECK: begin
                    fail_mask_out <= fail_mask_out | mismatch;
                    // Mask still clear means no earlier vector of this run failed.
                    if ((fail_mask_out == '0) && (|mismatch)) begin
                        fail_vector_out <= v_q[N_IN-1:0];
                    end
                    // Pass is resolved on the way into DONE so it is valid with done_out.
                    if (v_last) begin
                        pass_out <= ((fail_mask_out | mismatch) == '0);
                    end else begin
                        v_q <= v_q + (N_IN + 1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out  = (state != IDLE);
    assign done_out  = (state == DONE);
    assign dut_a_out = ((state == APPLY) || (state == SETTLE) || (state == CHECK))
                       ? {CHANNELS{v_q[N_IN-1:0]}} : '0;

endmodule

// File: tb/tb_ic_gate_tester.sv
// Testbench for ic_gate_tester with default parameters. A behavioural gate
// model (truth table per gate type, optional stuck-at faults per channel)
// drives dut_y_in from dut_a_out. Edge numbering: a start "at k" means
// start_in is high in the cycle beginning at edge k.
module tb_ic_gate_tester;

    localparam int CH = 4;
    localparam int NI = 2;
    localparam int SC = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       mode = 3'd0;
    logic [CH*NI-1:0] dut_a;
    logic [CH-1:0]    dut_y;
    logic             busy, done, pass;
    logic [CH-1:0]    mask;
    logic [NI-1:0]    fvec;
    logic             err;

    logic [2:0]       model = 3'd1;
    logic [CH-1:0]    st1 = '0;
    logic [CH-1:0]    st0 = '0;
    logic [3:0]       tt [7];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    ic_gate_tester #(.CHANNELS(CH), .N_IN(NI), .SETTLE_CYCLES(SC)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .start_in        (start),
        .mode_in         (mode),
        .dut_a_out       (dut_a),
        .dut_y_in        (dut_y),
        .busy_out        (busy),
        .done_out        (done),
        .pass_out        (pass),
        .fail_mask_out   (mask),
        .fail_vector_out (fvec),
        .err_mode_out    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Truth tables indexed by input vector {a1,a0}; encoding follows mode_in.
    initial begin
        tt[0] = 4'b0111; // NAND
        tt[1] = 4'b0001; // NOR
        tt[2] = 4'b1000; // AND
        tt[3] = 4'b1110; // OR
        tt[4] = 4'b0110; // XOR
        tt[5] = 4'b1001; // XNOR
        tt[6] = 4'b0101; // NOT a0
    end

    always_comb begin
        dut_y = '0;
        for (int c = 0; c < CH; c++) begin
            dut_y[c] = tt[model][dut_a[c*NI +: NI]];
            if (st1[c]) dut_y[c] = 1'b1;
            if (st0[c]) dut_y[c] = 1'b0;
        end
    end

    typedef struct {
        logic [2:0] mode;
        logic [2:0] model;
        logic [3:0] st1;
        logic [3:0] st0;
        int         lat;
        logic       pass;
        logic [3:0] mask;
        logic [1:0] fvec;
        logic       err;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic goto_cycle(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle start pulse; k is the edge that begins the start cycle.
    task automatic start_run(input logic [2:0] m, output int k);
        @(posedge clk);
        #1;
        k = cyc;
        start = 1'b1;
        mode = m;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns in the done cycle (sampled at its negedge) or after a bounded wait.
    task automatic wait_done(input int k, input int lat, input string name);
        int seen;
        seen = -1;
        for (int i = 0; i < 100 && seen < 0; i++) begin
            @(negedge clk);
            if (done) seen = cyc;
        end
        check({name, "_latency"}, 32'(seen - k), 32'(lat));
    endtask

    initial begin
        int k, k2, bad;

        tbl[0]  = '{3'd1, 3'd1, 4'b0000, 4'b0000, 17, 1'b1, 4'b0000, 2'b00, 1'b0};
        tbl[1]  = '{3'd1, 3'd1, 4'b0100, 4'b0000, 17, 1'b0, 4'b0100, 2'b01, 1'b0};
        tbl[2]  = '{3'd0, 3'd1, 4'b0000, 4'b0000, 17, 1'b0, 4'b1111, 2'b01, 1'b0};
        tbl[3]  = '{3'd7, 3'd1, 4'b0000, 4'b0000,  1, 1'b0, 4'b1111, 2'b00, 1'b1};
        tbl[4]  = '{3'd2, 3'd2, 4'b0000, 4'b0000, 17, 1'b1, 4'b0000, 2'b00, 1'b0};
        tbl[5]  = '{3'd3, 3'd3, 4'b0000, 4'b0000, 17, 1'b1, 4'b0000, 2'b00, 1'b0};
        tbl[6]  = '{3'd4, 3'd4, 4'b0000, 4'b0000, 17, 1'b1, 4'b0000, 2'b00, 1'b0};
        tbl[7]  = '{3'd5, 3'd5, 4'b0000, 4'b0000, 17, 1'b1, 4'b0000, 2'b00, 1'b0};
        tbl[8]  = '{3'd6, 3'd6, 4'b0000, 4'b0000, 17, 1'b1, 4'b0000, 2'b00, 1'b0};
        tbl[9]  = '{3'd6, 3'd0, 4'b0000, 4'b0000, 17, 1'b0, 4'b1111, 2'b01, 1'b0};
        tbl[10] = '{3'd4, 3'd3, 4'b0000, 4'b0000, 17, 1'b0, 4'b1111, 2'b11, 1'b0};
        tbl[11] = '{3'd2, 3'd2, 4'b0000, 4'b0001, 17, 1'b0, 4'b0001, 2'b11, 1'b0};
        tbl[12] = '{3'd0, 3'd0, 4'b1000, 4'b0000, 17, 1'b0, 4'b1000, 2'b11, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_dut_a", 32'(dut_a), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pass", 32'(pass), 32'h0);
        check("rst_mask", 32'(mask), 32'h0);
        check("rst_fvec", 32'(fvec), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // Table-driven runs
        for (int r = 0; r < 13; r++) begin
            model = tbl[r].model;
            st1   = tbl[r].st1;
            st0   = tbl[r].st0;
            start_run(tbl[r].mode, k);
            wait_done(k, tbl[r].lat, $sformatf("row%0d", r));
            check($sformatf("row%0d_pass", r), 32'(pass), 32'(tbl[r].pass));
            check($sformatf("row%0d_mask", r), 32'(mask), 32'(tbl[r].mask));
            check($sformatf("row%0d_fvec", r), 32'(fvec), 32'(tbl[r].fvec));
            check($sformatf("row%0d_err", r), 32'(err), 32'(tbl[r].err));
            check($sformatf("row%0d_busy_in_done", r), 32'(busy), 32'h1);
            check($sformatf("row%0d_dut_a_in_done", r), 32'(dut_a), 32'h0);
        end

        // Results hold in idle after a failing run
        repeat (3) @(negedge clk);
        check("hold_mask", 32'(mask), 32'h8);
        check("hold_fvec", 32'(fvec), 32'h3);
        check("hold_busy", 32'(busy), 32'h0);

        // NOR sweep: stimulus steps and busy window
        model = 3'd1;
        st1 = '0;
        st0 = '0;
        start_run(3'd1, k);
        for (int c = 1; c <= 18; c++) begin
            logic [1:0] vv;
            @(negedge clk);
            vv = 2'((c - 1) / 4);
            if (c <= 16) check($sformatf("step_dut_a_k%0d", c), 32'(dut_a), 32'({4{vv}}));
            else         check($sformatf("step_dut_a_k%0d", c), 32'(dut_a), 32'h0);
            check($sformatf("step_busy_k%0d", c), 32'(busy), (c <= 17) ? 32'h1 : 32'h0);
            check($sformatf("step_done_k%0d", c), 32'(done), (c == 17) ? 32'h1 : 32'h0);
        end
        check("step_pass", 32'(pass), 32'h1);

        // Reset mid-sweep, then a fresh run
        start_run(3'd1, k);
        goto_cycle(k + 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_dut_a", 32'(dut_a), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_mask", 32'(mask), 32'h0);
        check("midrst_pass", 32'(pass), 32'h0);
        bad = 0;
        while (cyc < k + 10) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check("midrst_no_done", 32'(bad), 32'h0);
        goto_cycle(k + 10);
        start = 1'b1;
        k2 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(k, 27, "midrst_restart");
        check("midrst_restart_pass", 32'(pass), 32'h1);
        check("midrst_restart_k", 32'(k2 - k), 32'd10);

        // start held high, mode toggled mid-sweep
        @(posedge clk);
        #1;
        start = 1'b1;
        mode = 3'd1;
        k = cyc;
        goto_cycle(k + 5);
        mode = 3'd0;
        wait_done(k, 17, "held");
        check("held_pass", 32'(pass), 32'h1);
        check("held_mask", 32'(mask), 32'h0);
        @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("held_rerun_busy", 32'(busy), 32'h1);
        #1;
        start = 1'b0;
        wait_done(k + 18, 17, "held_second");
        check("held_second_pass", 32'(pass), 32'h0);
        check("held_second_mask", 32'(mask), 32'hF);
        check("held_second_fvec", 32'(fvec), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
